// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Owns the single register-file write port and shares it between the
// pipeline W-stage writeback, which has fixed priority and zero latency, and
// the mult/div late writeback, which is queued in a small FIFO and drained
// into idle write-port cycles. It also keeps a per-register pending
// scoreboard for the hazard unit, and asks for a W-stage bubble when the
// queue head has waited too long.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   w_we/w_a3/w_wd/w_pc8    pipeline writeback request (priority requester)
//   md_valid/md_ready       mult/div writeback handshake into the FIFO
//   md_a3/md_wd/md_pc8      mult/div writeback payload
//   md_issue/md_issue_a3    mult/div issue, marks the destination busy
//   rf_we/rf_a3/rf_wd/rf_pc8  register-file write port
//   busy                    per-register outstanding mult/div write flags
//   stall_req               request to bubble the W-stage writeback
//   q_count                 FIFO occupancy
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_we,
    input  logic [4:0]               w_a3,
    input  logic [31:0]              w_wd,
    input  logic [31:0]              w_pc8,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [4:0]               md_a3,
    input  logic [31:0]              md_wd,
    input  logic [31:0]              md_pc8,
    input  logic                     md_issue,
    input  logic [4:0]               md_issue_a3,
    output logic                     rf_we,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    output logic [31:0]              rf_pc8,
    output logic [31:0]              busy,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc8;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [31:0]     r_busy;
    logic [SW-1:0]   r_starve;
    logic            r_stall;

    logic            w_pw;
    logic            w_empty;
    logic            w_pop;
    logic            w_accept;
    logic            w_push;
    entry_t          w_head;
    logic [31:0]     w_busy_nxt;
    logic [SW-1:0]   w_starve_nxt;

    // A write to r0 is architecturally a no-op, so it never claims the port.
    assign w_pw     = w_we && (w_a3 != 5'd0);
    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rptr];
    assign w_pop    = !w_pw && !w_empty;

    // Readiness depends on occupancy only: a full queue refuses a push even
    // when the head drains in the same cycle.
    assign md_ready = (r_count < (AW+1)'(DEPTH));
    assign w_accept = md_valid && md_ready;
    // Results for r0 are acknowledged but never stored.
    assign w_push   = w_accept && (md_a3 != 5'd0);

    assign busy      = r_busy;
    assign stall_req = r_stall;
    assign q_count   = r_count;

    // Port mux: pipeline first, queue head second. The whole port is held
    // quiet while reset is asserted, independent of the pipeline inputs.
    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = '0;
        rf_wd  = '0;
        rf_pc8 = '0;
        if (reset && w_pw) begin
            rf_we  = 1'b1;
            rf_a3  = w_a3;
            rf_wd  = w_wd;
            rf_pc8 = w_pc8;
        end else if (reset && !w_empty) begin
            rf_we  = 1'b1;
            rf_a3  = w_head.a3;
            rf_wd  = w_head.wd;
            rf_pc8 = w_head.pc8;
        end
    end

    // Scoreboard update: the clear from a drained entry is applied before
    // the set from a new issue so that a same-register collision stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head.a3] = 1'b0;
        end
        if (md_issue && (md_issue_a3 != 5'd0)) begin
            w_busy_nxt[md_issue_a3] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Starvation counter: counts cycles the head was blocked by the pipeline,
    // saturating so it cannot wrap back below the threshold.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (w_pw && (r_starve < SW'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{a3: md_a3, wd: md_wd, pc8: md_pc8};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_busy   <= w_busy_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt >= SW'(STARVE_MAX));
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Drives rf_wb_arbiter through directed scenarios and a constrained random
// phase. Queued mult/div writes are pushed to a scoreboard queue at the edge
// that accepts them and popped when the write port is expected to drain them.
module tb_rf_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] w_pc8;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc8;
    logic        md_issue;
    logic [4:0]  md_issue_a3;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc8;
    logic [31:0] busy;
    logic        stall_req;
    logic [2:0]  q_count;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc8;
    } wr_t;

    wr_t         sbQueue[$];
    logic [31:0] modelBusy = '0;
    int          modelStarve = 0;
    logic        expStall = 1'b0;
    int          errors = 0;
    int          checks = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc8(w_pc8),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_a3(md_a3), .md_wd(md_wd), .md_pc8(md_pc8),
        .md_issue(md_issue), .md_issue_a3(md_issue_a3),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc8(rf_pc8),
        .busy(busy), .stall_req(stall_req), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Hard stop in case a scenario ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // PC+8 values are derived from the data so the pc8 path is exercised too.
    task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                 input logic mdv, input logic [4:0] mda3, input logic [31:0] mdwd,
                                 input logic iss, input logic [4:0] issa3);
        w_we        = we;
        w_a3        = a3;
        w_wd        = wd;
        w_pc8       = {wd[15:0], 16'h0008};
        md_valid    = mdv;
        md_a3       = mda3;
        md_wd       = mdwd;
        md_pc8      = ~mdwd;
        md_issue    = iss;
        md_issue_a3 = issa3;
    endtask

    // One clock cycle: check the combinational port and registered state
    // mid-cycle, then apply the expected effect of the coming edge.
    task automatic clockEdge();
        logic pw;
        logic popExp;
        logic acc;
        int   sizeBefore;
        wr_t  inEntry;
        wr_t  head;
        #2;
        pw         = w_we && (w_a3 != 5'd0);
        sizeBefore = sbQueue.size();
        popExp     = (sizeBefore > 0) && !pw;
        acc        = md_valid && (sizeBefore < DEPTH);
        inEntry    = '{md_a3, md_wd, md_pc8};
        checkOutput("q_count", q_count, sizeBefore);
        checkOutput("md_ready", md_ready, sizeBefore < DEPTH);
        checkOutput("busy", busy, modelBusy);
        checkOutput("stall_req", stall_req, expStall);
        if (pw) begin
            checkOutput("pipe rf_we", rf_we, 1);
            checkOutput("pipe rf_a3", rf_a3, w_a3);
            checkOutput("pipe rf_wd", rf_wd, w_wd);
            checkOutput("pipe rf_pc8", rf_pc8, w_pc8);
        end else if (popExp) begin
            head = sbQueue[0];
            checkOutput("drain rf_we", rf_we, 1);
            checkOutput("drain rf_a3", rf_a3, head.a3);
            checkOutput("drain rf_wd", rf_wd, head.wd);
            checkOutput("drain rf_pc8", rf_pc8, head.pc8);
        end else begin
            checkOutput("idle rf_we", rf_we, 0);
            checkOutput("idle rf_a3", rf_a3, 0);
            checkOutput("idle rf_wd", rf_wd, 0);
            checkOutput("idle rf_pc8", rf_pc8, 0);
        end
        @(posedge clk);
        if (popExp) begin
            head = sbQueue.pop_front();
            modelBusy[head.a3] = 1'b0;
        end
        if (md_issue && (md_issue_a3 != 5'd0)) begin
            modelBusy[md_issue_a3] = 1'b1;
        end
        if (acc && (inEntry.a3 != 5'd0)) begin
            sbQueue.push_back(inEntry);
        end
        if ((sizeBefore == 0) || popExp) begin
            modelStarve = 0;
        end else if (pw && (modelStarve < STARVE_MAX)) begin
            modelStarve = modelStarve + 1;
        end
        expStall = (modelStarve >= STARVE_MAX);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset q_count", q_count, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rf_we", rf_we, 0);
        checkOutput("reset stall_req", stall_req, 0);
        reset = 1'b1;

        // Pipeline-only writes, including the r0 no-op.
        applyStimulus(1, 5'd8, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        clockEdge();
        applyStimulus(1, 5'd0, 32'hCAFEF00D, 0, 0, 0, 0, 0);
        clockEdge();

        // Issue marks r9 busy; the late result then drains and clears it.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        clockEdge();
        checkOutput("busy9 set", busy[9], 1);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h12345678, 0, 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();
        checkOutput("busy9 cleared", busy[9], 0);

        // Fill the queue while the pipeline owns the port every cycle.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(16 + i), 32'hB000_0000 + i, 0, 0);
            clockEdge();
        end
        checkOutput("full md_ready", md_ready, 0);
        checkOutput("full q_count", q_count, DEPTH);
        checkOutput("full stall_req", stall_req, 1);
        // Stall honoured: head drains, but the fifth push is refused.
        applyStimulus(0, 0, 0, 1, 5'd30, 32'hB000_00FF, 0, 0);
        clockEdge();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            clockEdge();
        end
        checkOutput("full drained", sbQueue.size(), 0);

        // Starvation: one entry blocked by the pipeline for three cycles.
        applyStimulus(0, 0, 0, 1, 5'd12, 32'h5A5A_0001, 0, 0);
        clockEdge();
        for (int i = 0; i < STARVE_MAX; i++) begin
            applyStimulus(1, 5'd3, 32'h0000_1000 + i, 0, 0, 0, 0, 0);
            clockEdge();
        end
        checkOutput("starve stall raised", stall_req, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        clockEdge();
        checkOutput("starve stall dropped", stall_req, 0);

        // Same-cycle drain of r4 and new issue to r4: stays busy.
        applyStimulus(0, 0, 0, 1, 5'd4, 32'h4444_4444, 1, 5'd4);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4);
        clockEdge();
        checkOutput("busy4 kept", busy[4], 1);
        applyStimulus(1, 5'd2, 32'h2222_2222, 1, 5'd0, 32'h0BAD_0BAD, 0, 0);
        clockEdge();
        checkOutput("r0 push dropped", q_count, 0);

        // Asynchronous reset mid-cycle with entries queued and r5 busy.
        applyStimulus(1, 5'd1, 32'h1111_0000, 1, 5'd20, 32'hC000_0020, 1, 5'd5);
        clockEdge();
        applyStimulus(1, 5'd1, 32'h1111_0001, 1, 5'd21, 32'hC000_0021, 0, 0);
        clockEdge();
        checkOutput("pre-reset q_count", q_count, 2);
        #2;
        applyStimulus(1, 5'd7, 32'h7777_7777, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checkOutput("async q_count", q_count, 0);
        checkOutput("async busy", busy, 0);
        checkOutput("async rf_we", rf_we, 0);
        checkOutput("async stall_req", stall_req, 0);
        sbQueue.delete();
        modelBusy   = '0;
        modelStarve = 0;
        expStall    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("post-reset md_ready", md_ready, 1);

        // Random traffic that respects the stall contract.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(expStall ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
            clockEdge();
        end

        // Drain whatever is left, bounded.
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            clockEdge();
        end
        checkOutput("final drained", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters.
- Requester 1 is the pipeline W-stage writeback, which has fixed priority and is never delayed.
- Requester 2 is the multiply/divide unit's late result writeback, which is buffered in a FIFO and drained into idle write-port cycles.
- Also keeps a per-register pending scoreboard for the hazard unit, and raises a writeback-stall request when the queued writes are being starved.

Parameters:
- DEPTH, 4, number of mult/div writeback FIFO entries (power of two, >=2).
- STARVE_MAX, 3, number of cycles the FIFO head may wait before stall_req is raised.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- w_we  in  1  pipeline writeback enable.
- w_a3  in  5  pipeline destination register.
- w_wd  in  32  pipeline write data.
- w_pc8  in  32  pipeline PC+8 (passed through for the write log).
- md_valid  in  1  mult/div writeback request.
- md_ready  out  1  FIFO can accept an entry.
- md_a3  in  5  mult/div destination register.
- md_wd  in  32  mult/div result.
- md_pc8  in  32  PC+8 of the issuing instruction.
- md_issue  in  1  mult/div instruction issued; marks md_issue_a3 as pending.
- md_issue_a3  in  5  destination register of the issued instruction.
- rf_we  out  1  register-file write enable.
- rf_a3  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- rf_pc8  out  32  PC+8 forwarded to the register file.
- busy  out  32  scoreboard, one bit per register; bit r=1 means a mult/div write to r is outstanding.
- stall_req  out  1  request to the hazard unit to bubble W-stage writeback.
- q_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, q_count=0, busy=0, starve counter=0, stall_req=0.
  - rf_we forced to 0 for as long as reset is low.
- Pipeline write valid: pw = w_we && (w_a3!=0).
- Port arbitration (combinational, same cycle):
  - If pw: rf_* = {1, w_a3, w_wd, w_pc8}. Pipeline write latency is 0 cycles.
  - Else if FIFO non-empty: rf_* = {1, head.a3, head.wd, head.pc8}; head pops at the next rising edge.
  - Else: rf_we=0, and rf_a3, rf_wd, rf_pc8 = 0.
- Enqueue:
  - md_ready = (q_count < DEPTH); it depends on occupancy only.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Accept at the rising edge when md_valid && md_ready.
  - md_a3==0 is accepted and dropped (not enqueued; scoreboard untouched).
  - An entry pushed into an empty FIFO is first drivable on the cycle after acceptance, so minimum queued latency is 1 cycle.
- Simultaneous push and pop: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Scoreboard:
  - md_issue && md_issue_a3!=0 sets busy[md_issue_a3] at the edge.
  - A popped entry clears busy[head.a3] at the edge.
  - Same-cycle set and clear of the same register: set wins.
  - busy[0] is hard 0.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and pw=1.
  - It resets to 0 on any pop or when the FIFO is empty.
  - stall_req is registered: it is 1 when counter >= STARVE_MAX, and drops the cycle after the pop.
  - The hazard unit guarantees w_we=0 on the cycle following stall_req=1.
- No WAW checking is done against pw. The hazard unit uses busy to prevent it.

Test Plan:
- Reset: drive reset=0 mid-run with 2 entries queued and busy[5]=1 -> immediately q_count=0, busy=0, rf_we=0, stall_req=0; after release, md_ready=1.
- Pipeline only: w_we=1, w_a3=8, w_wd=0xDEADBEEF -> same cycle rf_we=1, rf_a3=8, rf_wd=0xDEADBEEF; with w_a3=0 -> rf_we=0.
- Queue drain and scoreboard:
  - Stimulus: md_issue with a3=9, later push {9, 0x12345678} with w_we=0.
  - Required: busy[9]=1 from issue; next cycle rf_we=1, rf_a3=9, rf_wd=0x12345678; busy[9]=0 after that edge.
- Full and contention:
  - Stimulus: pipeline writes every cycle; push DEPTH entries.
  - Required: md_ready=0 at q_count=4; a 5th md_valid is not accepted; no entry lost or reordered (FIFO order checked on drain).
- Starvation:
  - Stimulus: one entry queued, pw=1 continuously.
  - Required: stall_req=1 after 3 waiting cycles; bench drops w_we; entry writes that cycle; stall_req=0 the next cycle.
- Set/clear collision: pop of reg 4 and md_issue_a3=4 in the same cycle -> busy[4] remains 1; md_a3=0 push -> q_count unchanged.
